btn_debouncer: RTL

- Input-conditioning stage directly upstream of the LED sequencer; feeds its i_btn bus.
- Synchronises raw board buttons to CLK100MHZ, debounces each one independently, and produces a clean level plus one-cycle rise and fall pulses per button.
- Downstream logic can therefore act on single-cycle press events instead of keeping its own previous-state registers.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_debounce_ch.sv | 122 ++++++++++++
 rtl/btn_debouncer.sv | 42 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared FSM encoding and timing constants for the button debouncer.
// 100 MHz defaults plus short simulation overrides.
package btn_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } btn_state_t;

   // 10 ms debounce and 1 s long-press at 100 MHz
   localparam int DEB_CYCLES_DEF  = 1000000;
   localparam int NB_DEB_DEF      = 20;
   localparam int LONG_CYCLES_DEF = 100000000;

   // Short values so a bench can walk every transition in a few cycles
   localparam int DEB_CYCLES_SIM  = 4;
   localparam int NB_DEB_SIM      = 3;
   localparam int LONG_CYCLES_SIM = 16;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, optional long-press counter (BTN_DEB_LONGPRESS_EN).
// Level change and rise/fall pulse land DEB_CYCLES+1 edges after sync1 samples the edge; no backpressure.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int NB_DEB      = NB_DEB_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic CLK100MHZ,
   input  logic reset,
   input  logic btn_raw,
   output logic btn,
   output logic btn_rise,
   output logic btn_fall
`ifdef BTN_DEB_LONGPRESS_EN
   ,
   output logic btn_long
`endif
);

   localparam logic [NB_DEB-1:0] CNT_LAST = NB_DEB'(DEB_CYCLES - 1);

   logic              sync1;
   logic              sync2;
   btn_state_t        state;
   logic [NB_DEB-1:0] cnt;

`ifdef BTN_DEB_LONGPRESS_EN
   localparam int NB_LONG = $clog2(LONG_CYCLES + 1);
   localparam logic [NB_LONG-1:0] HOLD_LAST = NB_LONG'(LONG_CYCLES - 1);
   // Parking one past the pulse value gives one pulse per press
   localparam logic [NB_LONG-1:0] HOLD_SAT  = NB_LONG'(LONG_CYCLES);
   logic [NB_LONG-1:0] hold;
`else
   wire unused_long_cfg = |LONG_CYCLES;
`endif

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         state    <= S_LOW;
         cnt      <= '0;
         btn      <= 1'b0;
         btn_rise <= 1'b0;
         btn_fall <= 1'b0;
`ifdef BTN_DEB_LONGPRESS_EN
         hold     <= '0;
         btn_long <= 1'b0;
`endif
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         btn_rise <= 1'b0;
         btn_fall <= 1'b0;
         case (state)
            S_LOW: begin
               if (sync2) begin
                  state <= S_WAIT_HIGH;
                  cnt   <= NB_DEB'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            S_WAIT_HIGH: begin
               if (!sync2) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state    <= S_HIGH;
                  cnt      <= '0;
                  btn      <= 1'b1;
                  btn_rise <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HIGH: begin
               if (!sync2) begin
                  state <= S_WAIT_LOW;
                  cnt   <= NB_DEB'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            S_WAIT_LOW: begin
               if (sync2) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state    <= S_LOW;
                  cnt      <= '0;
                  btn      <= 1'b0;
                  btn_fall <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_LOW;
               cnt   <= '0;
               btn   <= 1'b0;
            end
         endcase
`ifdef BTN_DEB_LONGPRESS_EN
         btn_long <= 1'b0;
         if (state == S_HIGH || state == S_WAIT_LOW) begin
            if (hold == HOLD_LAST) begin
               btn_long <= 1'b1;
               hold     <= HOLD_SAT;
            end else if (hold != HOLD_SAT) begin
               hold <= hold + 1'b1;
            end
         end else begin
            hold <= '0;
         end
`endif
      end
   end

endmodule

// File: rtl/btn_debouncer.sv
// Debounces NB_BTN raw buttons into clean levels plus one-cycle rise/fall (and BTN_DEB_LONGPRESS_EN long) pulses.
// Outputs move DEB_CYCLES+1 edges after sync1 samples a clean edge; no backpressure.
module btn_debouncer
   import btn_pkg::*;
#(
   parameter int NB_BTN      = 4,
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int NB_DEB      = NB_DEB_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic [NB_BTN-1:0] i_btn_raw,
   output logic [NB_BTN-1:0] o_btn,
   output logic [NB_BTN-1:0] o_btn_rise,
   output logic [NB_BTN-1:0] o_btn_fall
`ifdef BTN_DEB_LONGPRESS_EN
   ,
   output logic [NB_BTN-1:0] o_btn_long
`endif
);

   for (genvar g = 0; g < NB_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEB_CYCLES  (DEB_CYCLES),
         .NB_DEB      (NB_DEB),
         .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
         .CLK100MHZ (CLK100MHZ),
         .reset     (reset),
         .btn_raw   (i_btn_raw[g]),
         .btn       (o_btn[g]),
         .btn_rise  (o_btn_rise[g]),
         .btn_fall  (o_btn_fall[g])
`ifdef BTN_DEB_LONGPRESS_EN
         ,
         .btn_long  (o_btn_long[g])
`endif
      );
   end

endmodule
